// File: rtl/fw_local_intc_dispatch.sv
// Interrupt dispatcher: programs the local controller mask, reads pending on irq,
// resolves software/hardware source priority and hands the id to a consumer.
//
// state   | meaning
// INIT    | write MASK_INIT to the controller mask register
// IDLE    | wait for irq
// RD_PEND | read the pending register
// EVAL    | resolve id from captured pending word
// CLR_SW  | clear the software request
// OUT     | present id to the consumer
// HOLD    | ignore irq while the controller's irq output catches up
module fw_local_intc_dispatch #(
    parameter int unsigned N_SRCS    = 1,
    parameter int unsigned MASK_INIT = 0,
    parameter int unsigned HOLDOFF   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        irq,
    output logic [1:0]  i_adr,
    output logic [31:0] i_dat_w,
    input  logic [31:0] i_dat_r,
    output logic        i_we,
    output logic        i_valid,
    input  logic        i_ready,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [4:0]  id,
    output logic        id_sw,
    output logic [7:0]  spurious_cnt
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_RD_PEND, S_EVAL, S_CLR_SW, S_OUT, S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pending;
    logic [4:0]  r_id;
    logic        r_id_sw;
    logic [7:0]  r_spur;
    logic [3:0]  r_hold_cnt;

    logic        w_src_hit;
    logic [4:0]  w_src_idx;
    logic        w_valid;
    logic [1:0]  w_adr;
    logic        w_we;
    logic [31:0] w_dat;
    logic        w_unused_pend;

    // Pending bits between N_SRCS and 30 carry no meaning here.
    assign w_unused_pend = ^r_pending;

    always_comb begin
        w_src_hit = 1'b0;
        w_src_idx = 5'd0;
        for (int k = int'(N_SRCS) - 1; k >= 0; k--) begin
            if (r_pending[k]) begin
                w_src_hit = 1'b1;
                w_src_idx = 5'(k);
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_valid = 1'b0;
        w_adr   = 2'd0;
        w_we    = 1'b1;
        w_dat   = 32'd0;
        case (r_state)
            S_INIT: begin
                w_valid = 1'b1;
                w_adr   = 2'd1;
                w_dat   = 32'(MASK_INIT);
                if (i_ready) w_next = S_IDLE;
            end
            S_IDLE: begin
                if (irq) w_next = S_RD_PEND;
            end
            S_RD_PEND: begin
                w_valid = 1'b1;
                w_we    = 1'b0;
                if (i_ready) w_next = S_EVAL;
            end
            S_EVAL: begin
                if (r_pending[31])  w_next = S_CLR_SW;
                else if (w_src_hit) w_next = S_OUT;
                else                w_next = S_HOLD;
            end
            S_CLR_SW: begin
                w_valid = 1'b1;
                w_adr   = 2'd2;
                if (i_ready) w_next = S_OUT;
            end
            S_OUT: begin
                if (id_ready) w_next = S_HOLD;
            end
            S_HOLD: begin
                if (r_hold_cnt == 4'd0) w_next = S_IDLE;
            end
            default: w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_pending  <= 32'd0;
            r_id       <= 5'd0;
            r_id_sw    <= 1'b0;
            r_spur     <= 8'd0;
            r_hold_cnt <= 4'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_RD_PEND: begin
                    if (i_ready) r_pending <= i_dat_r;
                end
                S_EVAL: begin
                    if (r_pending[31]) begin
                        r_id    <= 5'd0;
                        r_id_sw <= 1'b1;
                    end else if (w_src_hit) begin
                        r_id    <= w_src_idx;
                        r_id_sw <= 1'b0;
                    end else begin
                        if (r_spur != 8'hFF) r_spur <= r_spur + 8'd1;
                        r_hold_cnt <= 4'(HOLDOFF - 1);
                    end
                end
                S_OUT: begin
                    if (id_ready) r_hold_cnt <= 4'(HOLDOFF - 1);
                end
                S_HOLD: begin
                    if (r_hold_cnt != 4'd0) r_hold_cnt <= r_hold_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Bus and id outputs are forced quiet for as long as reset is held.
    assign i_valid      = w_valid & ~reset;
    assign i_adr        = reset ? 2'd0 : w_adr;
    assign i_we         = w_we & ~reset;
    assign i_dat_w      = reset ? 32'd0 : w_dat;
    assign id_valid     = (r_state == S_OUT) & ~reset;
    assign id           = r_id;
    assign id_sw        = r_id_sw;
    assign spurious_cnt = r_spur;

endmodule

// File: tb/tb_fw_local_intc_dispatch.sv
// Bench for fw_local_intc_dispatch: directed and random pending words checked
// against a priority/saturation model of the dispatcher.
module tb_fw_local_intc_dispatch;

    localparam int N_SRCS    = 4;
    localparam int MASK_INIT = 5;
    localparam int HOLDOFF   = 2;

    logic        clock;
    logic        reset;
    logic        irq;
    logic [1:0]  i_adr;
    logic [31:0] i_dat_w;
    logic [31:0] i_dat_r;
    logic        i_we;
    logic        i_valid;
    logic        i_ready;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id;
    logic        id_sw;
    logic [7:0]  spurious_cnt;

    fw_local_intc_dispatch #(
        .N_SRCS(N_SRCS), .MASK_INIT(MASK_INIT), .HOLDOFF(HOLDOFF)
    ) dut (
        .clock(clock), .reset(reset), .irq(irq),
        .i_adr(i_adr), .i_dat_w(i_dat_w), .i_dat_r(i_dat_r), .i_we(i_we),
        .i_valid(i_valid), .i_ready(i_ready),
        .id_valid(id_valid), .id_ready(id_ready), .id(id), .id_sw(id_sw),
        .spurious_cnt(spurious_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [31:0] dat;
    } xfer_t;

    xfer_t xq[$];
    int    valid_cycles = 0;
    int    n_err = 0;
    int    n_chk = 0;
    int    model_spur = 0;

    always @(negedge clock) begin
        if (i_valid) valid_cycles++;
        if (i_valid && i_ready) xq.push_back('{i_we, i_adr, i_dat_w});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int bump_spur(input int cur, input int n);
        return (cur + n > 255) ? 255 : cur + n;
    endfunction

    // Caller and task both sit at posedge+1 with the DUT idle.
    task automatic run_irq(input logic [31:0] pend, input int rdy_gap, input int ack_gap);
        logic [3:0]  low;
        logic        exp_sw;
        logic        exp_out;
        logic [4:0]  exp_id;
        logic        seen;
        int          x0;
        int          exp_n;
        low     = pend[3:0];
        exp_sw  = pend[31];
        exp_out = exp_sw || (low != 4'd0);
        exp_id  = 5'd0;
        if (!exp_sw && low != 4'd0) exp_id = 5'($clog2(low & (~low + 4'd1)));
        x0 = xq.size();

        i_ready = (rdy_gap == 0);
        i_dat_r = (rdy_gap == 0) ? pend : ~pend;
        irq     = 1'b1;
        @(posedge clock); #1;
        irq = 1'b0;
        for (int k = 0; k < rdy_gap; k++) begin
            @(negedge clock);
            check("rd_stall_valid", 32'(i_valid), 32'd1);
            check("rd_stall_adr", 32'(i_adr), 32'd0);
            check("rd_stall_we", 32'(i_we), 32'd0);
            @(posedge clock); #1;
        end
        i_ready = 1'b1;
        i_dat_r = pend;

        id_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clock);
            if (id_valid) seen = 1'b1;
            else begin @(posedge clock); #1; end
        end
        check("id_valid_seen", 32'(seen), 32'(exp_out));
        if (seen) begin
            check("id", 32'(id), 32'(exp_id));
            check("id_sw", 32'(id_sw), 32'(exp_sw));
            for (int k = 0; k < ack_gap; k++) begin
                @(posedge clock); #1;
                @(negedge clock);
                check("id_hold_valid", 32'(id_valid), 32'd1);
                check("id_hold", 32'({id_sw, id}), 32'({exp_sw, exp_id}));
            end
            id_ready = 1'b1;
            @(posedge clock); #1;
            id_ready = 1'b0;
            @(negedge clock);
            check("id_valid_drop", 32'(id_valid), 32'd0);
        end
        repeat (HOLDOFF + 3) @(posedge clock);
        #1;

        if (!exp_out) model_spur = bump_spur(model_spur, 1);
        check("spurious_cnt", 32'(spurious_cnt), 32'(model_spur));
        exp_n = exp_sw ? 2 : 1;
        check("xfer_count", 32'(xq.size() - x0), 32'(exp_n));
        if (xq.size() - x0 >= 1) begin
            check("rd_we", 32'(xq[x0].we), 32'd0);
            check("rd_adr", 32'(xq[x0].adr), 32'd0);
        end
        if (exp_sw && (xq.size() - x0 >= 2)) begin
            check("clr_we", 32'(xq[x0+1].we), 32'd1);
            check("clr_adr", 32'(xq[x0+1].adr), 32'd2);
            check("clr_dat", xq[x0+1].dat, 32'd0);
        end
    endtask

    initial begin
        int x0;
        int v0;
        int nreads;
        logic [31:0] pend;
        logic        seen;

        reset = 1'b1; irq = 1'b0; i_ready = 1'b1; id_ready = 1'b0; i_dat_r = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_i_valid", 32'(i_valid), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id", 32'(id), 32'd0);
        check("rst_id_sw", 32'(id_sw), 32'd0);
        check("rst_spur", 32'(spurious_cnt), 32'd0);
        check("rst_bus", 32'({i_adr, i_we}), 32'd0);
        check("rst_dat_w", i_dat_w, 32'd0);

        @(posedge clock); #1;
        x0 = xq.size();
        v0 = valid_cycles;
        reset = 1'b0;
        @(negedge clock);
        check("init_valid_first", 32'(i_valid), 32'd1);
        repeat (5) @(posedge clock);
        #1;
        check("init_xfers", 32'(xq.size() - x0), 32'd1);
        check("init_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        if (xq.size() - x0 >= 1) begin
            check("init_we", 32'(xq[x0].we), 32'd1);
            check("init_adr", 32'(xq[x0].adr), 32'd1);
            check("init_dat", xq[x0].dat, 32'(MASK_INIT));
        end

        run_irq(32'h0000_000C, 0, 3);
        run_irq(32'h8000_0001, 0, 1);
        run_irq(32'h0000_0000, 0, 0);
        run_irq(32'h0000_0002, 3, 0);
        run_irq(32'h7FFF_FFF0, 1, 0);
        run_irq(32'h0000_0008, 0, 2);

        // irq held high on an empty pending word: one read per RD/EVAL/HOLD/IDLE loop.
        x0 = xq.size();
        i_ready = 1'b1; i_dat_r = 32'd0; irq = 1'b1;
        repeat (30) @(posedge clock);
        #1;
        irq = 1'b0;
        nreads = xq.size() - x0;
        repeat (8) @(posedge clock);
        #1;
        check("holdoff_reads", 32'(nreads), 32'd6);
        check("holdoff_total", 32'(xq.size() - x0), 32'd6);
        model_spur = bump_spur(model_spur, 6);
        check("holdoff_spur", 32'(spurious_cnt), 32'(model_spur));

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0:       pend = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF);
                1:       pend = ($urandom & 32'h7FFF_FFF0) | 32'($urandom_range(1, 15));
                2:       pend = $urandom & 32'h7FFF_FFF0;
                default: pend = 32'd0;
            endcase
            run_irq(pend, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        i_dat_r = 32'd0; irq = 1'b1;
        repeat (5 * 260) @(posedge clock);
        #1;
        irq = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        model_spur = 255;
        check("spur_saturate", 32'(spurious_cnt), 32'(model_spur));

        // Reset while a dispatched id is waiting for the consumer.
        i_dat_r = 32'h0000_0004; i_ready = 1'b1; irq = 1'b1;
        @(posedge clock); #1;
        irq = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clock);
            if (id_valid) seen = 1'b1;
            else begin @(posedge clock); #1; end
        end
        check("rst_out_seen", 32'(seen), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_out_id_valid", 32'(id_valid), 32'd0);
        check("rst_out_i_valid", 32'(i_valid), 32'd0);
        check("rst_out_id", 32'(id), 32'd0);
        check("rst_out_spur", 32'(spurious_cnt), 32'd0);
        @(posedge clock); #1;
        x0 = xq.size();
        reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("reinit_xfers", 32'(xq.size() - x0), 32'd1);
        if (xq.size() - x0 >= 1) begin
            check("reinit_adr", 32'(xq[x0].adr), 32'd1);
            check("reinit_dat", xq[x0].dat, 32'(MASK_INIT));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fw_local_intc_dispatch.md
FW_LOCAL_INTC_DISPATCH -- requirements
Module: fw_local_intc_dispatch

Interface
REQ-001 Parameter N_SRCS, default 1, number of interrupt sources at the controller (legal range 1..31).
REQ-002 Parameter MASK_INIT, default 0, value written to the controller mask register after reset.
REQ-003 Parameter HOLDOFF, default 2, idle cycles before irq is re-sampled (legal range 1..15).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 irq  input  1  interrupt request from the local interrupt controller.
REQ-007 i_adr  output  2  initiator word address: 0 = pending, 1 = mask, 2 = sw_req.
REQ-008 i_dat_w  output  32  initiator write data.
REQ-009 i_dat_r  input  32  initiator read data, valid in the cycle i_ready is high.
REQ-010 i_we  output  1  1 = write, 0 = read.
REQ-011 i_valid  output  1  initiator request valid.
REQ-012 i_ready  input  1  target accepts the request.
REQ-013 id_valid  output  1  dispatched interrupt id is valid.
REQ-014 id_ready  input  1  consumer accepts the id.
REQ-015 id  output  5  index of the dispatched source (0 when id_sw = 1).
REQ-016 id_sw  output  1  the dispatched interrupt is the software request.
REQ-017 spurious_cnt  output  8  count of spurious interrupts, saturating.

Function
REQ-018 The FSM states SHALL be INIT, IDLE, RD_PEND, EVAL, CLR_SW, OUT and HOLD.
REQ-019 A bus transfer SHALL complete on a rising edge where i_valid and i_ready are both 1.
REQ-020 While i_valid = 1, i_adr, i_we and i_dat_w SHALL remain stable until the transfer completes; i_valid SHALL only drop after completion.
REQ-021 INIT SHALL write MASK_INIT (zero-extended to 32 bits) to address 1, then go to IDLE.
REQ-022 IDLE: when irq = 1, go to RD_PEND in the next cycle.
REQ-023 RD_PEND SHALL read address 0, capture i_dat_r into a pending register on completion, then go to EVAL.
REQ-024 EVAL, one cycle: if pending[31] = 1, set id_sw = 1 and id = 0, then go to CLR_SW.
REQ-025 Otherwise, if any pending[N_SRCS-1:0] bit is set, set id to the lowest set index and id_sw = 0, then go to OUT.
REQ-026 Otherwise, increment spurious_cnt (saturating at 255), then go to HOLD.
REQ-027 Bits of pending between N_SRCS and 30 SHALL be ignored.
REQ-028 CLR_SW SHALL write 0 to address 2, then go to OUT.
REQ-029 OUT SHALL hold id_valid = 1 with id and id_sw stable until id_valid and id_ready are both 1, then go to HOLD.
REQ-030 id_valid SHALL be 1 only in OUT.
REQ-031 HOLD SHALL count HOLDOFF cycles with irq ignored, then go to IDLE; this covers the controller's registered irq lag.
REQ-032 The pending-register, id and spurious_cnt registers SHALL change only in the states named above.
REQ-033 Source-level changes during RD_PEND through OUT SHALL NOT alter the id being dispatched.
REQ-034 i_valid SHALL be 1 only in INIT, RD_PEND and CLR_SW.
REQ-035 i_we SHALL be 0 only in RD_PEND.

Reset
REQ-036 reset = 1 SHALL synchronously force state INIT, with i_valid = 0, id_valid = 0, id = 0, id_sw = 0, spurious_cnt = 0, the pending register = 0 and the HOLD counter = 0.
REQ-037 On reset, i_adr, i_dat_w and i_we SHALL be 0.
REQ-038 Reset asserted in any state, including mid-transfer or mid-OUT, SHALL abort the operation with no partial completion.
REQ-039 i_valid SHALL become 1 in the first cycle after reset = 0.

Verification
REQ-040 Reset release, MASK_INIT = 0x5, target i_ready tied to 1 -> exactly one write, adr 1, dat 0x00000005; i_valid = 1 for 1 cycle.
REQ-041 irq = 1, pending read returns 0x0000000C -> id = 2, id_sw = 0, id_valid held until id_ready = 1; no write to address 2.
REQ-042 Pending read returns 0x80000001 -> write of 0 to address 2 occurs, then id_sw = 1, id = 0.
REQ-043 Pending read returns 0x00000000 -> no id_valid; spurious_cnt goes from 0 to 1; 256 repeats leave it at 255.
REQ-044 i_ready held 0 for 3 cycles during RD_PEND -> i_valid, i_adr = 0 and i_we = 0 stay stable; capture occurs only in the i_ready cycle.
REQ-045 reset pulsed while in OUT with id_valid = 1 -> id_valid = 0 in the next cycle; INIT mask write is reissued.
